spike_aer_encoder: RTL and testbench

//  Transmit side of the spike interface: collects spike outputs of N_NEURONS

---
 rtl/snn_pkg.sv | 19 +
 rtl/spike_aer_encoder_if.sv | 48 ++++
 rtl/rr_arbiter.sv | 37 +++
 rtl/spike_aer_encoder.sv | 107 ++++++++++
 tb/tb_spike_aer_encoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike AER encoder slice.
// Optional timestamp field enabled by SPIKE_AER_TIMESTAMP_EN.
package snn_pkg;

  localparam int N_NEURONS_DEF = 16;
  localparam int TS_W_DEF      = 16;

  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ADDR_W_DEF = clog2_safe(N_NEURONS_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [TS_W_DEF-1:0]   ts;
  } aer_event_t;

endpackage

// File: rtl/spike_aer_encoder_if.sv
// AER valid/ready event stream between encoder and router.
// aer_ts exists only with SPIKE_AER_TIMESTAMP_EN.
interface spike_aer_encoder_if
  import snn_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int TS_W      = TS_W_DEF
);

  localparam int ADDR_W = clog2_safe(N_NEURONS);

  logic              aer_valid;
  logic              aer_ready;
  logic [ADDR_W-1:0] aer_addr;

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_W-1:0]   aer_ts;

  modport master (
    output aer_valid,
    output aer_addr,
    output aer_ts,
    input  aer_ready
  );

  modport slave (
    input  aer_valid,
    input  aer_addr,
    input  aer_ts,
    output aer_ready
  );
`else
  localparam int unused_ts_w = TS_W;

  modport master (
    output aer_valid,
    output aer_addr,
    input  aer_ready
  );

  modport slave (
    input  aer_valid,
    input  aer_addr,
    output aer_ready
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping N-1 -> 0.
module rr_arbiter
  import snn_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = clog2_safe(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int          kk;
  logic [W-1:0] k;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    kk         = 0;
    k          = '0;
    for (int i = 0; i < N; i++) begin
      kk = int'(ptr) + i;
      if (kk >= N) kk = kk - N;
      k = W'(kk);
      if (!any && req[k]) begin
        any           = 1'b1;
        gnt_idx       = k;
        gnt_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: captures per-neuron pulses, round-robin serialises.
// Define SPIKE_AER_TIMESTAMP_EN to stamp events with a tick counter.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int TS_W      = TS_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_NEURONS-1:0] spike_i,
  input  logic                 tick_i,
  input  logic                 ovf_clr_i,
  spike_aer_encoder_if.master  aer,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int ADDR_W = clog2_safe(N_NEURONS);

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [N_NEURONS-1:0] gnt_onehot, clr;
  logic [ADDR_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 any, free, drop;

  rr_arbiter #(.N(N_NEURONS)) u_arb (
    .req        (pending_q),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_comb begin
    free      = !valid_q || aer.aer_ready;
    clr       = (free && any) ? gnt_onehot : '0;
    // a new pulse on a granted bit re-arms it rather than dropping
    pending_d = (pending_q & ~clr) | spike_i;
    drop      = |(spike_i & pending_q & ~clr);
    ovf_d     = drop | (ovf_q & ~ovf_clr_i);
    valid_d   = valid_q;
    addr_d    = addr_q;
    rr_ptr_d  = rr_ptr_q;
    if (free) begin
      valid_d = any;
      if (any) begin
        addr_d   = gnt_idx;
        rr_ptr_d = (gnt_idx == ADDR_W'(N_NEURONS - 1))
                 ? '0 : gnt_idx + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign aer.aer_valid = valid_q;
  assign aer.aer_addr  = addr_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = (|pending_q) | valid_q;

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] ev_ts_q, ev_ts_d;

  // event takes the pre-increment value when a tick lands on the load
  always_comb begin
    ts_d    = ts_q + TS_W'(tick_i);
    ev_ts_d = ev_ts_q;
    if (free && any) ev_ts_d = ts_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q    <= '0;
      ev_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      ev_ts_q <= ev_ts_d;
    end
  end

  assign aer.aer_ts = ev_ts_q;
`else
  logic unused_tick;
  localparam int unused_ts_w = TS_W;
  assign unused_tick = tick_i;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder with a cycle-level
// behavioural model and randomized traffic.
module tb_spike_aer_encoder;

  localparam int N  = 16;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  spike;
  logic          tick;
  logic          ovf_clr;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  spike_aer_encoder_if #(.N_NEURONS(N), .TS_W(TW)) aer ();

  spike_aer_encoder #(.N_NEURONS(N), .TS_W(TW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .spike_i    (spike),
    .tick_i     (tick),
    .ovf_clr_i  (ovf_clr),
    .aer        (aer.master),
    .overflow_o (overflow),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // behavioural reference state
  bit m_pend [N];
  int m_ptr;
  bit m_valid;
  int m_addr;
  bit m_ovf;
  int m_ts;
  int m_ets;
  int dut_log [$];

  function automatic bit m_busy();
    bit b;
    b = m_valid;
    for (int k = 0; k < N; k++) if (m_pend[k]) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_addr = 0;
    m_ovf = 1'b0; m_ts = 0; m_ets = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] sp, input bit rdy,
                            input bit tk, input bit clr);
    bit free;
    bit drop;
    int gi;
    free = !m_valid || rdy;
    gi   = -1;
    if (free)
      for (int i = 0; i < N; i++)
        if (gi < 0 && m_pend[(m_ptr + i) % N]) gi = (m_ptr + i) % N;
    drop = 1'b0;
    for (int k = 0; k < N; k++)
      if (sp[k] && m_pend[k] && k != gi) drop = 1'b1;
    if (gi >= 0) m_pend[gi] = 1'b0;
    for (int k = 0; k < N; k++) if (sp[k]) m_pend[k] = 1'b1;
    if (free) begin
      if (gi >= 0) begin
        m_valid = 1'b1; m_addr = gi; m_ets = m_ts;
        m_ptr = (gi + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (tk) m_ts = (m_ts + 1) % (1 << TW);
  endtask

  // called at posedge+1: drive, log DUT transfer, advance model, cross edge
  task automatic step(input logic [N-1:0] sp, input bit rdy,
                      input bit tk, input bit clr);
    spike = sp; aer.aer_ready = rdy; tick = tk; ovf_clr = clr;
    if (aer.aer_valid && rdy) dut_log.push_back(int'(aer.aer_addr));
    model_edge(sp, rdy, tk, clr);
    @(posedge clk); #1;
    spike = '0; tick = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    spike = '0; tick = 1'b0; ovf_clr = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    dut_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (aer.aer_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", aer.aer_valid);
    end
    n_checks++;
    if (aer.aer_addr !== 4'd0) begin
      n_fail++; $display("FAIL reset_addr got %0d want 0", aer.aer_addr);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf got %b want 0", overflow);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(16'h0001, 1, 0, 0);
    n_checks++;
    if (aer.aer_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_c1 valid got %b want 0", aer.aer_valid);
    end
    step('0, 1, 0, 0);
    n_checks++;
    if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL single_c2 valid/addr got %b/%0d want 1/0",
               aer.aer_valid, aer.aer_addr);
    end
    step('0, 1, 0, 0);
    n_checks++;
    if (aer.aer_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle valid/busy got %b/%b want 0/0",
               aer.aer_valid, busy);
    end
  endtask

  task automatic test_pattern();
    int exp_a [4] = '{0, 5, 10, 15};
    do_reset();
    step(16'h8421, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step('0, 1, 0, 0);
      n_checks++;
      if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 4'(exp_a[i])) begin
        n_fail++;
        $display("FAIL pattern_ev%0d valid/addr got %b/%0d want 1/%0d",
                 i, aer.aer_valid, aer.aer_addr, exp_a[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL pattern_busy_last got %b want 1", busy);
    end
    step('0, 1, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || aer.aer_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pattern_busy_fall busy/valid got %b/%b want 0/0",
               busy, aer.aer_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(16'h0008, 0, 0, 0);
    step('0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step('0, 0, 0, 0);
      n_checks++;
      if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 4'd3) begin
        n_fail++;
        $display("FAIL hold_c%0d valid/addr got %b/%0d want 1/3",
                 i, aer.aer_valid, aer.aer_addr);
      end
    end
    dut_log.delete();
    step('0, 1, 0, 0);
    step('0, 1, 0, 0);
    n_checks++;
    if (dut_log.size() != 1 || aer.aer_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_xfer count/valid got %0d/%b want 1/0",
               dut_log.size(), aer.aer_valid);
    end
    n_checks++;
    if (dut_log.size() > 0 && dut_log[0] != 3) begin
      n_fail++; $display("FAIL hold_xfer_addr got %0d want 3", dut_log[0]);
    end
  endtask

  task automatic test_overflow();
    int n2;
    do_reset();
    step(16'h0080, 0, 0, 0);
    step('0, 0, 0, 0);
    step(16'h0004, 0, 0, 0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_first got %b want 0", overflow);
    end
    step(16'h0004, 0, 0, 0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop got %b want 1", overflow);
    end
    step('0, 0, 0, 1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got %b want 0", overflow);
    end
    step(16'h0004, 0, 0, 1);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop_wins got %b want 1", overflow);
    end
    step('0, 0, 0, 1);
    dut_log.delete();
    for (int i = 0; i < 4; i++) step('0, 1, 0, 0);
    n2 = 0;
    foreach (dut_log[i]) if (dut_log[i] == 2) n2++;
    n_checks++;
    if (n2 != 1 || dut_log.size() != 2) begin
      n_fail++;
      $display("FAIL ovf_single_ev addr2/total got %0d/%0d want 1/2",
               n2, dut_log.size());
    end
  endtask

  task automatic test_all_ones();
    bit seen [N];
    int nseen;
    do_reset();
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    step('1, 1, 0, 0);
    for (int c = 1; c < 40; c++) begin
      step('1, 1, 0, 0);
      n_checks++;
      if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 4'((c - 1) % N)) begin
        n_fail++;
        $display("FAIL allones_c%0d valid/addr got %b/%0d want 1/%0d",
                 c, aer.aer_valid, aer.aer_addr, (c - 1) % N);
      end
      if (aer.aer_valid === 1'b1) seen[int'(aer.aer_addr)] = 1'b1;
    end
    nseen = 0;
    for (int k = 0; k < N; k++) if (seen[k]) nseen++;
    n_checks++;
    if (nseen != N) begin
      n_fail++; $display("FAIL allones_starve got %0d want %0d", nseen, N);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step('1, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (aer.aer_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst valid/busy got %b/%b want 0/0",
               aer.aer_valid, busy);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step('0, 1, 0, 0);
      n_checks++;
      if (aer.aer_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_stale c%0d valid got %b want 0",
                           i, aer.aer_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] sp;
    bit rdy, tk, clr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sp  = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0;
      rdy = ($urandom_range(0, 3) != 0);
      tk  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(sp, rdy, tk, clr);
      n_checks++;
      if (aer.aer_valid !== m_valid ||
          (m_valid && aer.aer_addr !== 4'(m_addr))) begin
        n_fail++;
        $display("FAIL rand_c%0d valid/addr got %b/%0d want %b/%0d",
                 c, aer.aer_valid, aer.aer_addr, m_valid, m_addr);
      end
      n_checks++;
      if (overflow !== m_ovf || busy !== m_busy()) begin
        n_fail++;
        $display("FAIL rand_c%0d ovf/busy got %b/%b want %b/%b",
                 c, overflow, busy, m_ovf, m_busy());
      end
`ifdef SPIKE_AER_TIMESTAMP_EN
      n_checks++;
      if (m_valid && aer.aer_ts !== 16'(m_ets)) begin
        n_fail++;
        $display("FAIL rand_c%0d ts got %0d want %0d",
                 c, aer.aer_ts, m_ets);
      end
`endif
    end
  endtask

`ifdef SPIKE_AER_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    for (int i = 0; i < 3; i++) step('0, 1, 1, 0);
    step(16'h0001, 1, 0, 0);
    step('0, 1, 0, 0);
    n_checks++;
    if (aer.aer_valid !== 1'b1 || aer.aer_ts !== 16'd3) begin
      n_fail++;
      $display("FAIL ts_three valid/ts got %b/%0d want 1/3",
               aer.aer_valid, aer.aer_ts);
    end
    step(16'h0002, 1, 0, 0);
    step('0, 1, 1, 0);
    n_checks++;
    if (aer.aer_addr !== 4'd1 || aer.aer_ts !== 16'd3) begin
      n_fail++;
      $display("FAIL ts_preinc addr/ts got %0d/%0d want 1/3",
               aer.aer_addr, aer.aer_ts);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    spike = '0; tick = 1'b0; ovf_clr = 1'b0;
    aer.aer_ready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_pattern();
    test_backpressure();
    test_overflow();
    test_all_ones();
    test_reset_mid();
    test_random();
`ifdef SPIKE_AER_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
